// File: rtl/dram_responder_if.sv
// CPU data-port bundle between the core (master) and dram_responder (slave).
// Carries the address/store lines, combinational read data, LED drive and the fault flag.
interface dram_responder_if;
   logic [31:0] dAddr;
   logic [31:0] dataOut;
   logic        DRAMwe;
   logic [31:0] dataIn;
   logic [15:0] leds;
   logic        fault;

   modport master (output dAddr, output dataOut, output DRAMwe,
                   input  dataIn, input  leds,    input  fault);
   modport slave  (input  dAddr, input  dataOut, input  DRAMwe,
                   output dataIn, output leds,    output fault);
endinterface

// File: rtl/dram_responder.sv
// Data-memory responder with zero-latency reads and a small MMIO status window.
// Optional store-fault monitor (FAULT_STATUS/FAULT_ADDR, fault output) is enabled by `define DRAM_FAULT_EN.
module dram_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
   input  logic             clk,
   input  logic             reset,
   dram_responder_if.slave  bus
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_L   = 30'(DEPTH_WORDS);
   localparam logic [7:0]  OFF_CYCLE = 8'h00;
   localparam logic [7:0]  OFF_STORE = 8'h04;
   localparam logic [7:0]  OFF_LED   = 8'h08;
`ifdef DRAM_FAULT_EN
   localparam logic [7:0]  OFF_FSTAT = 8'h0C;
   localparam logic [7:0]  OFF_FADDR = 8'h10;
`endif

   logic        is_mmio;
   logic        in_range;
   logic [29:0] word_idx;
   logic [7:0]  mmio_off;
   logic        mmio_we;
   logic        mem_we;
   logic        store_fault;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] stores_q, stores_d;
   logic [15:0] led_q, led_d;
   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] mem_rdata;
   logic [31:0] rdata;

   assign is_mmio   = (bus.dAddr[31:8] == MMIO_BASE[31:8]);
   assign word_idx  = bus.dAddr[31:2];
   assign in_range  = (word_idx < DEPTH_L);
   assign mmio_off  = bus.dAddr[7:0];
   assign mem_rdata = mem_q[word_idx[AW-1:0]];

   always_comb begin
      mmio_we  = bus.DRAMwe && is_mmio;
      // A store seen while reset is held must not land in the array.
      mem_we   = bus.DRAMwe && !is_mmio && in_range && !store_fault && reset;
      cycle_d  = cycle_q + 32'd1;
      stores_d = mem_we ? stores_q + 32'd1 : stores_q;
      led_d    = (mmio_we && mmio_off == OFF_LED) ? bus.dataOut[15:0] : led_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q  <= '0;
         stores_q <= '0;
         led_q    <= '0;
      end else begin
         cycle_q  <= cycle_d;
         stores_q <= stores_d;
         led_q    <= led_d;
      end
   end

   // The array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[word_idx[AW-1:0]] <= bus.dataOut;
   end

`ifdef DRAM_FAULT_EN
   logic [2:0]  fstat_q, fstat_d;
   logic [31:0] faddr_q, faddr_d;

   always_comb begin
      store_fault = bus.DRAMwe && !is_mmio && ((bus.dAddr[1:0] != 2'b00) || !in_range);
      fstat_d     = fstat_q;
      faddr_d     = faddr_q;
      if (store_fault) begin
         fstat_d = {!in_range, (bus.dAddr[1:0] != 2'b00), 1'b1};
         if (!fstat_q[0]) faddr_d = bus.dAddr;
      end else if (mmio_we && mmio_off == OFF_FSTAT && bus.dataOut[0]) begin
         fstat_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fstat_q <= '0;
         faddr_q <= '0;
      end else begin
         fstat_q <= fstat_d;
         faddr_q <= faddr_d;
      end
   end

   assign bus.fault = fstat_q[0];
`else
   assign store_fault = 1'b0;
   assign bus.fault   = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      if (is_mmio) begin
         case (mmio_off)
            OFF_CYCLE: rdata = cycle_q;
            OFF_STORE: rdata = stores_q;
            OFF_LED:   rdata = {16'h0000, led_q};
`ifdef DRAM_FAULT_EN
            OFF_FSTAT: rdata = {29'd0, fstat_q};
            OFF_FADDR: rdata = faddr_q;
`endif
            default:   rdata = '0;
         endcase
      end else if (in_range) begin
         rdata = mem_rdata;
      end
   end

   assign bus.dataIn = rdata;
   assign bus.leds   = led_q;
endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: directed scenarios plus randomized traffic
// checked against a word-level memory/register model.
module tb_dram_responder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dram_responder_if bus ();

   dram_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(32'hFFFF_FF00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [31:0] m_mem [int];
   logic [31:0] m_cycle, m_stores, m_faddr;
   logic [15:0] m_led;
   logic [2:0]  m_fstat;

   function automatic void model_reset();
      m_cycle = 0; m_stores = 0; m_led = 0; m_fstat = 0; m_faddr = 0;
   endfunction

   function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
      int idx = int'(a[31:2]);
      if (a[31:8] == 24'hFFFFFF) begin
         if (a[7:0] == 8'h08) m_led = d[15:0];
`ifdef DRAM_FAULT_EN
         if (a[7:0] == 8'h0C && d[0]) m_fstat = 3'b000;
`endif
      end else begin
`ifdef DRAM_FAULT_EN
         if (a[1:0] != 2'b00 || idx >= 1024) begin
            if (!m_fstat[0]) m_faddr = a;
            m_fstat = {idx >= 1024, a[1:0] != 2'b00, 1'b1};
            return;
         end
`endif
         if (idx < 1024) begin
            m_mem[idx] = d;
            m_stores++;
         end
      end
   endfunction

   // Returns {known, value}; unwritten array words are unknown.
   function automatic logic [32:0] exp_read(input logic [31:0] a);
      int idx = int'(a[31:2]);
      if (a[31:8] == 24'hFFFFFF) begin
         case (a[7:0])
            8'h00: return {1'b1, m_cycle};
            8'h04: return {1'b1, m_stores};
            8'h08: return {1'b1, 16'h0000, m_led};
`ifdef DRAM_FAULT_EN
            8'h0C: return {1'b1, 29'd0, m_fstat};
            8'h10: return {1'b1, m_faddr};
`endif
            default: return {1'b1, 32'd0};
         endcase
      end
      if (idx >= 1024) return {1'b1, 32'd0};
      if (m_mem.exists(idx)) return {1'b1, m_mem[idx]};
      return 33'd0;
   endfunction

   // Drivers
   task automatic step();
      @(posedge clk);
      #1;
      if (reset) m_cycle++;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      bus.dAddr  = a;
      bus.DRAMwe = 1'b0;
      #1;
      v = bus.dataIn;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, output logic [31:0] same);
      bus.dAddr   = a;
      bus.dataOut = d;
      bus.DRAMwe  = 1'b1;
      #1;
      same = bus.dataIn;
      step();
      bus.DRAMwe = 1'b0;
      model_store(a, d);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      bus.dAddr = 0; bus.dataOut = 0; bus.DRAMwe = 0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      rd(32'hFFFF_FF00, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp %h", v, 32'h0); end
      rd(32'hFFFF_FF04, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_stores got %h exp %h", v, 32'h0); end
      checks++; if (bus.leds !== 16'h0) begin errors++; $display("FAIL reset_leds got %h exp %h", bus.leds, 16'h0); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp %b", bus.fault, 1'b0); end
      for (int i = 1; i <= 3; i++) begin
         step();
         rd(32'hFFFF_FF00, v);
         checks++; if (v !== 32'(i)) begin errors++; $display("FAIL cycle_count got %h exp %h", v, 32'(i)); end
      end
   endtask

   task automatic test_store();
      logic [31:0] s, v;
      do_store(32'h0000_0010, 32'h1111_1111, s);
      do_store(32'h0000_0010, 32'hDEAD_BEEF, s);
      checks++; if (s !== 32'h1111_1111) begin errors++; $display("FAIL store_same_cycle got %h exp %h", s, 32'h1111_1111); end
      rd(32'h0000_0010, v);
      checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_next_cycle got %h exp %h", v, 32'hDEAD_BEEF); end
      rd(32'h0000_0012, v);
      checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_lowbits got %h exp %h", v, 32'hDEAD_BEEF); end
      rd(32'hFFFF_FF04, v);
      checks++; if (v !== 32'd2) begin errors++; $display("FAIL store_count got %h exp %h", v, 32'd2); end
   endtask

   task automatic test_led();
      logic [31:0] s, v;
      do_store(32'hFFFF_FF08, 32'h0001_A5A5, s);
      checks++; if (s !== 32'h0) begin errors++; $display("FAIL led_same_cycle got %h exp %h", s, 32'h0); end
      checks++; if (bus.leds !== 16'hA5A5) begin errors++; $display("FAIL leds_out got %h exp %h", bus.leds, 16'hA5A5); end
      rd(32'hFFFF_FF08, v);
      checks++; if (v !== 32'h0000_A5A5) begin errors++; $display("FAIL led_read got %h exp %h", v, 32'h0000_A5A5); end
      rd(32'hFFFF_FF04, v);
      checks++; if (v !== 32'd2) begin errors++; $display("FAIL led_stores got %h exp %h", v, 32'd2); end
      do_store(32'hFFFF_FF00, 32'h1234_5678, s);
      rd(32'hFFFF_FF00, v);
      checks++; if (v !== m_cycle) begin errors++; $display("FAIL cycle_ro got %h exp %h", v, m_cycle); end
      do_store(32'hFFFF_FF40, 32'hFFFF_FFFF, s);
      rd(32'hFFFF_FF40, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp %h", v, 32'h0); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL unmapped_fault got %b exp %b", bus.fault, 1'b0); end
   endtask

`ifdef DRAM_FAULT_EN
   task automatic test_fault();
      logic [31:0] s, v;
      do_store(32'h0000_0013, 32'h9999_9999, s);
      do_store(32'h0000_1000, 32'h7777_7777, s);
      rd(32'h0000_0010, v);
      checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fault_suppress got %h exp %h", v, 32'hDEAD_BEEF); end
      rd(32'hFFFF_FF04, v);
      checks++; if (v !== 32'd2) begin errors++; $display("FAIL fault_stores got %h exp %h", v, 32'd2); end
      rd(32'hFFFF_FF0C, v);
      checks++; if (v !== 32'h5) begin errors++; $display("FAIL fault_status got %h exp %h", v, 32'h5); end
      rd(32'hFFFF_FF10, v);
      checks++; if (v !== 32'h13) begin errors++; $display("FAIL fault_addr got %h exp %h", v, 32'h13); end
      checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_out got %b exp %b", bus.fault, 1'b1); end
      do_store(32'hFFFF_FF0C, 32'h1, s);
      rd(32'hFFFF_FF0C, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL fault_clear got %h exp %h", v, 32'h0); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_clear_out got %b exp %b", bus.fault, 1'b0); end
      do_store(32'h0000_1002, 32'h0, s);
      rd(32'hFFFF_FF0C, v);
      checks++; if (v !== 32'h7) begin errors++; $display("FAIL refault_status got %h exp %h", v, 32'h7); end
      rd(32'hFFFF_FF10, v);
      checks++; if (v !== 32'h1002) begin errors++; $display("FAIL refault_addr got %h exp %h", v, 32'h1002); end
      do_store(32'hFFFF_FF0C, 32'h1, s);
   endtask
`else
   task automatic test_no_fault();
      logic [31:0] s, v;
      do_store(32'h0000_0013, 32'hCAFE_F00D, s);
      rd(32'h0000_0010, v);
      checks++; if (v !== 32'hCAFE_F00D) begin errors++; $display("FAIL misaligned_write got %h exp %h", v, 32'hCAFE_F00D); end
      do_store(32'h0000_1000, 32'h7777_7777, s);
      rd(32'hFFFF_FF04, v);
      checks++; if (v !== 32'd3) begin errors++; $display("FAIL oor_dropped got %h exp %h", v, 32'd3); end
      rd(32'hFFFF_FF0C, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL fstat_absent got %h exp %h", v, 32'h0); end
      rd(32'hFFFF_FF10, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL faddr_absent got %h exp %h", v, 32'h0); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_tied got %b exp %b", bus.fault, 1'b0); end
   endtask
`endif

   task automatic test_cycle_wrap();
      logic [31:0] v;
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      rd(32'hFFFF_FF00, v);
      checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_preload got %h exp %h", v, 32'hFFFF_FFFE); end
      step();
      rd(32'hFFFF_FF00, v);
      checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max got %h exp %h", v, 32'hFFFF_FFFF); end
      step();
      rd(32'hFFFF_FF00, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp %h", v, 32'h0); end
      m_cycle = 32'h0;
   endtask

   task automatic test_random();
      logic [31:0] a, d, s, v;
      logic [32:0] e;
      logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h80, 8'hFC};
      for (int n = 0; n < 300; n++) begin
         d = $urandom;
         case ($urandom_range(0, 6))
            0: a = {20'd0, 5'($urandom_range(0, 31)), 7'd0} >> 5;
            1: a = {23'd0, 7'($urandom_range(0, 127))};
            2: a = 32'hFFFF_FF08;
            3: a = {24'hFFFFFF, offs[$urandom_range(0, 7)]};
            4: a = {17'd0, 13'($urandom_range(1024, 8191)), 2'b00};
            5: a = {23'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
            default: a = 32'hFFFF_FF0C;
         endcase
         e = exp_read(a);
         if ($urandom_range(0, 2) == 0) begin
            rd(a, v);
            if (e[32]) begin
               checks++; if (v !== e[31:0]) begin errors++; $display("FAIL rand_read a=%h got %h exp %h", a, v, e[31:0]); end
            end
            step();
         end else begin
            do_store(a, d, s);
            if (e[32]) begin
               checks++; if (s !== e[31:0]) begin errors++; $display("FAIL rand_same a=%h got %h exp %h", a, s, e[31:0]); end
            end
            e = exp_read(a);
            rd(a, v);
            if (e[32]) begin
               checks++; if (v !== e[31:0]) begin errors++; $display("FAIL rand_after a=%h got %h exp %h", a, v, e[31:0]); end
            end
         end
         rd(32'hFFFF_FF04, v);
         checks++; if (v !== m_stores) begin errors++; $display("FAIL rand_stores got %h exp %h", v, m_stores); end
         checks++; if (bus.leds !== m_led) begin errors++; $display("FAIL rand_leds got %h exp %h", bus.leds, m_led); end
         checks++; if (bus.fault !== m_fstat[0]) begin errors++; $display("FAIL rand_fault got %b exp %b", bus.fault, m_fstat[0]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] s, v;
      logic [32:0] e;
      do_store(32'hFFFF_FF08, 32'h0000_5A5A, s);
      for (int i = 0; i < 6; i++) do_store(32'h0000_0100 + 32'(i * 4), $urandom, s);
      bus.dAddr = 32'h0000_0120; bus.dataOut = 32'h0BAD_0BAD; bus.DRAMwe = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      m_mem.delete(32'h120 >> 2);
      #1;
      checks++; if (bus.leds !== 16'h0) begin errors++; $display("FAIL rstmid_leds got %h exp %h", bus.leds, 16'h0); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL rstmid_fault got %b exp %b", bus.fault, 1'b0); end
      rd(32'hFFFF_FF00, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_cycle got %h exp %h", v, 32'h0); end
      rd(32'hFFFF_FF04, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_stores got %h exp %h", v, 32'h0); end
      rd(32'hFFFF_FF08, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_led got %h exp %h", v, 32'h0); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         e = exp_read(32'h0000_0100 + 32'(i * 4));
         rd(32'h0000_0100 + 32'(i * 4), v);
         checks++; if (!e[32] || v !== e[31:0]) begin errors++; $display("FAIL rstmid_mem i=%0d got %h exp %h", i, v, e[31:0]); end
         step();
      end
      rd(32'hFFFF_FF00, v);
      checks++; if (v !== 32'd6) begin errors++; $display("FAIL rstmid_recount got %h exp %h", v, 32'd6); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_led();
`ifdef DRAM_FAULT_EN
      test_fault();
`else
      test_no_fault();
`endif
      test_cycle_wrap();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dram_responder.md
# dram_responder

Data-memory responder on the CPU data port. It accepts the core's address, write data and write strobe, and returns read data in the same cycle so single-cycle loads complete. It also hosts a small memory-mapped status window with a cycle counter, a store counter, an LED register and a store-fault monitor. It sits between the CPU data port and the board top level.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit data words in the array; power of two.
- MMIO_BASE, 32'hFFFF_FF00: base of the 256-byte MMIO window.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- dAddr  in  32  byte address from CPU (ALU result).
- dataOut  in  32  CPU store data.
- DRAMwe  in  1  CPU store strobe; store commits on the rising edge.
- dataIn  out  32  read data to CPU, combinational from dAddr.
- leds  out  16  LED register contents.
- fault  out  1  sticky store-fault flag (present only with DRAM_FAULT_EN; tied 0 otherwise).

## Operation
- Decode:
  - MMIO when dAddr[31:8] == MMIO_BASE[31:8].
  - Otherwise DRAM, with word index dAddr[31:2].
  - In range when index < DEPTH_WORDS.
- DRAM read: dataIn = mem[index], word-aligned; dAddr[1:0] is ignored for reads. An out-of-range read returns 0.
- DRAM store: when DRAMwe=1 at the edge, in range, and not suppressed by a fault, mem[index] <= dataOut and STORES increments.
- The array is not reset; contents are undefined until written.
- MMIO registers (offset from MMIO_BASE):
  - 0x00 CYCLE: RO, free-running, +1 every cycle, wraps 0xFFFFFFFF->0.
  - 0x04 STORES: RO, count of committed DRAM stores, wraps.
  - 0x08 LED: RW, bits[15:0]; reads are zero-extended; drives leds.
  - 0x0C FAULT_STATUS: bit0 sticky fault, bit1 last cause misaligned, bit2 last cause out-of-range. Writing 1 to bit0 clears all three bits.
  - 0x10 FAULT_ADDR: RO, dAddr of the first fault since the last clear.
- Unmapped MMIO offsets read 0; writes to them are ignored and are not faults. Writes to RO registers are ignored.
- The CPU has no read strobe, so faults are detected on stores only.
- A store fault occurs when DRAMwe=1, the address is in DRAM space, and either:
  - dAddr[1:0] != 0, or
  - the address is out of range.
- On a store fault, the store is suppressed: no array write and no STORES increment.
- On a store fault, set bit0 and update the cause bits. Capture FAULT_ADDR only if bit0 was 0 before the edge.
- A store fault and a FAULT_STATUS clear in the same cycle cannot both occur, because it is one store port. A fault raised the cycle after a clear is recorded normally.

## Timing
- Reads have zero latency: dataIn is purely combinational from dAddr, the array and the MMIO registers.
- Stores and MMIO writes take effect on the rising edge of clk. A read of the same address in the same cycle as the write returns the old value; the next cycle returns the new value.
- CYCLE reads the pre-increment value in the current cycle.
- Reset (reset=0), asynchronous, immediately sets:
  - CYCLE=0, STORES=0, LED=0, leds=0;
  - FAULT_STATUS=0, FAULT_ADDR=0, fault=0.
- Reset asserted mid-store: the store is lost and the array word is undefined only if reset coincides with the edge. The bench must not rely on that word.
- After reset deasserts, CYCLE reads 0 in the first cycle and counts from the first rising edge.
- fault follows FAULT_STATUS bit0, registered, so it is visible the cycle after the faulting edge.

## Configuration
- DRAM_FAULT_EN defined:
  - store-fault detection, suppression, FAULT_STATUS and FAULT_ADDR are implemented as above;
  - fault is driven.
- DRAM_FAULT_EN undefined:
  - misaligned stores write mem[dAddr[31:2]] (low bits ignored);
  - out-of-range stores are silently dropped without incrementing STORES;
  - offsets 0x0C and 0x10 read 0;
  - fault is constant 0.

## Test plan
- Reset low 3 cycles, release -> CYCLE read at 0xFFFFFF00 = 0 then increments by 1 per cycle; leds=0, fault=0, STORES=0.
- Store 0xDEADBEEF to 0x00000010, then read 0x00000010 -> same-cycle dataIn shows the old value; the next cycle shows 0xDEADBEEF; STORES=1.
- Write 0x0001A5A5 to 0xFFFFFF08 -> leds=16'hA5A5 after the edge; read returns 0x0000A5A5; STORES unchanged.
- (DRAM_FAULT_EN) Store to 0x00000013, then store to 0x00001000 with DEPTH_WORDS=1024:
  - both stores are suppressed;
  - FAULT_STATUS=0x5 after the second store;
  - FAULT_ADDR=0x00000013;
  - fault=1.
  - Write 1 to 0xFFFFFF0C -> FAULT_STATUS=0 and fault=0.
- Force CYCLE near wrap by running from a preloaded 0xFFFFFFFE (bench force) -> reads 0xFFFFFFFF, then 0x00000000.
- Assert reset during a stream of stores -> all counters and LED register are 0 immediately, without waiting for a clock edge.
